// File: rtl/ir_decode_regfile_if.sv
// Decode-stage bus: write port, IR load and immediate select from the controller,
// plus the registered decode results returned to it.
interface ir_decode_regfile_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic [15:0]       in_Inst;
  logic              in_IRWrite;
  logic              in_RegWrite;
  logic [REG_AW-1:0] in_WriteAddr;
  logic [DATA_W-1:0] in_Data;
  logic [1:0]        in_ImmSel;
  logic [15:0]       out_Inst;
  logic [REG_AW-1:0] out_Rd;
  logic [DATA_W-1:0] out_RegData1;
  logic [DATA_W-1:0] out_RegData2;
  logic [DATA_W-1:0] out_Imm;
  logic              out_Valid;

  modport master (
    output in_Inst, in_IRWrite, in_RegWrite, in_WriteAddr, in_Data, in_ImmSel,
    input  out_Inst, out_Rd, out_RegData1, out_RegData2, out_Imm, out_Valid
  );

  modport slave (
    input  in_Inst, in_IRWrite, in_RegWrite, in_WriteAddr, in_Data, in_ImmSel,
    output out_Inst, out_Rd, out_RegData1, out_RegData2, out_Imm, out_Valid
  );
endinterface

// File: rtl/ir_decode_regfile.sv
// Decode stage: instruction register, immediate generator and register file with
// registered read ports, write-through bypass and hardwired-zero r0.
module ir_decode_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4
) (
  input logic              CLK,
  input logic              RST,
  ir_decode_regfile_if.slave bus
);

  logic [15:0]              ir_q, ir_d;
  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [REG_AW-1:0]        rs1, rs2;
  logic                     wr_en;
  logic [REG_AW-1:0]        rd_q, rd_d;
  logic [DATA_W-1:0]        rdata1_q, rdata1_d;
  logic [DATA_W-1:0]        rdata2_q, rdata2_d;
  logic signed [DATA_W-1:0] imm_q, imm_d;
  logic                     irw_q, valid_q;

  function automatic logic signed [DATA_W-1:0] imm_gen(input logic [15:0] ir,
                                                       input logic [1:0]  sel);
    logic signed [3:0]  s4;
    logic signed [7:0]  s8;
    logic signed [11:0] s12;
    s4  = ir[3:0];
    s8  = ir[7:0];
    s12 = ir[11:0];
    case (sel)
      2'b00:   imm_gen = DATA_W'(s4);
      2'b01:   imm_gen = DATA_W'(s8);
      2'b10:   imm_gen = DATA_W'({ir[7:0], 8'h00});
      default: imm_gen = DATA_W'(s12);
    endcase
  endfunction

  // A same-edge write to a nonzero read address wins over the stale array entry.
  function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] addr,
                                                  input logic              we,
                                                  input logic [REG_AW-1:0] waddr,
                                                  input logic [DATA_W-1:0] wdata,
                                                  input logic [DATA_W-1:0] arr_val);
    if (addr == '0)
      read_port = '0;
    else if (we && (waddr == addr))
      read_port = wdata;
    else
      read_port = arr_val;
  endfunction

  always_comb begin
    rs1      = REG_AW'(ir_q[7:4]);
    rs2      = REG_AW'(ir_q[3:0]);
    wr_en    = bus.in_RegWrite && (bus.in_WriteAddr != '0);
    ir_d     = bus.in_IRWrite ? bus.in_Inst : ir_q;
    rd_d     = REG_AW'(ir_q[11:8]);
    rdata1_d = read_port(rs1, wr_en, bus.in_WriteAddr, bus.in_Data, regs_q[rs1]);
    rdata2_d = read_port(rs2, wr_en, bus.in_WriteAddr, bus.in_Data, regs_q[rs2]);
    imm_d    = imm_gen(ir_q, bus.in_ImmSel);
  end

  // Stage boundary: IR and register array
  always_ff @(posedge CLK) begin
    if (RST) begin
      ir_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ir_q <= ir_d;
      if (wr_en) regs_q[bus.in_WriteAddr] <= bus.in_Data;
    end
  end

  // Stage boundary: registered decode outputs, valid trails the IR load by one edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      irw_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      irw_q    <= bus.in_IRWrite;
      valid_q  <= irw_q;
    end
  end

  assign bus.out_Inst     = ir_q;
  assign bus.out_Rd       = rd_q;
  assign bus.out_RegData1 = rdata1_q;
  assign bus.out_RegData2 = rdata2_q;
  assign bus.out_Imm      = imm_q;
  assign bus.out_Valid    = valid_q;

endmodule

// File: tb/tb_ir_decode_regfile.sv
// Directed bench for ir_decode_regfile: per-edge vector table plus hand sequences
// for the r1..r15 reset sweep and back-to-back IR loads.
module tb_ir_decode_regfile;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;

  ir_decode_regfile_if #(.DATA_W(16), .REG_AW(4)) bus ();

  ir_decode_regfile #(.DATA_W(16), .NUM_REGS(16), .REG_AW(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        rst;
    logic        irw;
    logic        rw;
    logic [3:0]  waddr;
    logic [15:0] data;
    logic [15:0] inst;
    logic [1:0]  sel;
    logic [15:0] e_inst;
    logic [3:0]  e_rd;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    logic [15:0] e_imm;
    logic        e_vld;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic irw, input logic rw, input logic [3:0] waddr,
                       input logic [15:0] data, input logic [15:0] inst, input logic [1:0] sel);
    RST              = rst;
    bus.in_IRWrite   = irw;
    bus.in_RegWrite  = rw;
    bus.in_WriteAddr = waddr;
    bus.in_Data      = data;
    bus.in_Inst      = inst;
    bus.in_ImmSel    = sel;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //          rst  irw  rw   wa     data      inst      sel    e_inst    e_rd   e_d1      e_d2      e_imm     vld
    vecs[0]  = '{1'b1,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd0,16'h0000,4'h0,16'h0000,16'h0000,16'h0000,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b1,4'h3,16'h0001,16'h1337,2'd0,16'h1337,4'h0,16'h0000,16'h0000,16'h0000,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd0,16'h1337,4'h3,16'h0001,16'h0000,16'h0007,1'b1};
    vecs[3]  = '{1'b0,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd0,16'h1337,4'h3,16'h0001,16'h0000,16'h0007,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b1,4'h7,16'hBEEF,16'h0000,2'd0,16'h1337,4'h3,16'h0001,16'hBEEF,16'h0007,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd0,16'h1337,4'h3,16'h0001,16'hBEEF,16'h0007,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,4'h0,16'h0000,16'h1000,2'd0,16'h1000,4'h3,16'h0001,16'hBEEF,16'h0007,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,4'h0,16'h1234,16'h0000,2'd0,16'h1000,4'h0,16'h0000,16'h0000,16'h0000,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd0,16'h1000,4'h0,16'h0000,16'h0000,16'h0000,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b0,4'h0,16'h0000,16'h00F8,2'd0,16'h00F8,4'h0,16'h0000,16'h0000,16'h0000,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd0,16'h00F8,4'h0,16'h0000,16'h0000,16'hFFF8,1'b1};
    vecs[11] = '{1'b0,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd1,16'h00F8,4'h0,16'h0000,16'h0000,16'hFFF8,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd2,16'h00F8,4'h0,16'h0000,16'h0000,16'hF800,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd3,16'h00F8,4'h0,16'h0000,16'h0000,16'h00F8,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b0,4'h0,16'h0000,16'h0800,2'd3,16'h0800,4'h0,16'h0000,16'h0000,16'h00F8,1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd3,16'h0800,4'h8,16'h0000,16'h0000,16'hF800,1'b1};
    vecs[16] = '{1'b0,1'b1,1'b0,4'h0,16'h0000,16'h2F8A,2'd0,16'h2F8A,4'h8,16'h0000,16'h0000,16'h0000,1'b0};
    vecs[17] = '{1'b0,1'b0,1'b1,4'h8,16'h1111,16'h0000,2'd0,16'h2F8A,4'hF,16'h1111,16'h0000,16'hFFFA,1'b1};
    vecs[18] = '{1'b0,1'b0,1'b1,4'hA,16'h7FFF,16'h0000,2'd0,16'h2F8A,4'hF,16'h1111,16'h7FFF,16'hFFFA,1'b0};
    vecs[19] = '{1'b0,1'b1,1'b1,4'h3,16'h0005,16'h1337,2'd0,16'h1337,4'hF,16'h1111,16'h7FFF,16'hFFFA,1'b0};
    vecs[20] = '{1'b1,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd0,16'h0000,4'h0,16'h0000,16'h0000,16'h0000,1'b0};
    vecs[21] = '{1'b0,1'b1,1'b0,4'h0,16'h0000,16'h1337,2'd0,16'h1337,4'h0,16'h0000,16'h0000,16'h0000,1'b0};
    vecs[22] = '{1'b0,1'b0,1'b0,4'h0,16'h0000,16'h0000,2'd0,16'h1337,4'h3,16'h0000,16'h0000,16'h0007,1'b1};

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].irw, vecs[i].rw, vecs[i].waddr, vecs[i].data, vecs[i].inst, vecs[i].sel);
      check($sformatf("v%0d.inst", i), 32'(bus.out_Inst),     32'(vecs[i].e_inst));
      check($sformatf("v%0d.rd",   i), 32'(bus.out_Rd),       32'(vecs[i].e_rd));
      check($sformatf("v%0d.d1",   i), 32'(bus.out_RegData1), 32'(vecs[i].e_d1));
      check($sformatf("v%0d.d2",   i), 32'(bus.out_RegData2), 32'(vecs[i].e_d2));
      check($sformatf("v%0d.imm",  i), 32'(bus.out_Imm),      32'(vecs[i].e_imm));
      check($sformatf("v%0d.vld",  i), 32'(bus.out_Valid),    32'(vecs[i].e_vld));
    end

    // Reset sweep: every register reads back zero after a reset.
    drive(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 2'd0);
    for (int r = 1; r < 16; r++) begin
      logic [3:0] a;
      a = 4'(r);
      drive(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, {4'h0, a, a, a}, 2'd0);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 2'd0);
      check($sformatf("sweep%0d.rd", r), 32'(bus.out_Rd),       32'(a));
      check($sformatf("sweep%0d.d1", r), 32'(bus.out_RegData1), 32'h0);
      check($sformatf("sweep%0d.d2", r), 32'(bus.out_RegData2), 32'h0);
    end

    // Back-to-back loads keep valid high on consecutive cycles.
    drive(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 16'h0123, 2'd0);
    check("b2b.vld0", 32'(bus.out_Valid), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 16'h0456, 2'd0);
    check("b2b.vld1", 32'(bus.out_Valid), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 16'h0789, 2'd0);
    check("b2b.vld2", 32'(bus.out_Valid), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 2'd0);
    check("b2b.vld3", 32'(bus.out_Valid), 32'h1);
    check("b2b.inst", 32'(bus.out_Inst),  32'h0789);
    check("b2b.rd",   32'(bus.out_Rd),    32'h7);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 2'd0);
    check("b2b.vld4", 32'(bus.out_Valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
